// File: rtl/alu_pipe_core_if.sv
// Bus bundle between the stimulus driver, the ALU core and the result monitor.
// The driver owns the operand/command side, the core owns the result side.
interface alu_pipe_core_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic           ce;
  logic           mode;
  logic [M-1:0]   cmd;
  logic [1:0]     inp_valid;
  logic [N-1:0]   opa;
  logic [N-1:0]   opb;
  logic           cin;
  logic [2*N-1:0] res;
  logic           res_valid;
  logic           busy;
  logic           cout;
  logic           oflow;
  logic           e;
  logic           g;
  logic           l;
  logic           err;

  modport master (
    output ce, mode, cmd, inp_valid, opa, opb, cin,
    input  res, res_valid, busy, cout, oflow, e, g, l, err
  );

  modport slave (
    input  ce, mode, cmd, inp_valid, opa, opb, cin,
    output res, res_valid, busy, cout, oflow, e, g, l, err
  );
endinterface

// File: rtl/alu_pipe_core.sv
// Handshaked ALU core. Collects OPA/OPB, possibly in different cycles with a
// bounded wait, computes in one cycle (two for multiplies) and presents the
// result with a one-cycle res_valid strobe. Inputs are ignored while busy,
// except operand capture during the wait.
module alu_pipe_core #(
  parameter int N           = 8,
  parameter int M           = 4,
  parameter int WAIT_CYCLES = 16
) (
  input logic            clk,
  input logic            rst,
  alu_pipe_core_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(WAIT_CYCLES + 1);

  localparam logic [N:0]  ONE = 1;
  localparam logic [SW:0] NW  = N;

  // Arithmetic opcodes (mode = 1)
  localparam logic [M-1:0] A_ADD     = 0;
  localparam logic [M-1:0] A_SUB     = 1;
  localparam logic [M-1:0] A_ADD_CIN = 2;
  localparam logic [M-1:0] A_SUB_CIN = 3;
  localparam logic [M-1:0] A_INC_A   = 4;
  localparam logic [M-1:0] A_DEC_A   = 5;
  localparam logic [M-1:0] A_INC_B   = 6;
  localparam logic [M-1:0] A_DEC_B   = 7;
  localparam logic [M-1:0] A_CMP     = 8;
  localparam logic [M-1:0] A_MUL_INC = 9;
  localparam logic [M-1:0] A_MUL_SHL = 10;

  // Logical opcodes (mode = 0)
  localparam logic [M-1:0] L_AND    = 0;
  localparam logic [M-1:0] L_NAND   = 1;
  localparam logic [M-1:0] L_OR     = 2;
  localparam logic [M-1:0] L_NOR    = 3;
  localparam logic [M-1:0] L_XOR    = 4;
  localparam logic [M-1:0] L_XNOR   = 5;
  localparam logic [M-1:0] L_NOT_A  = 6;
  localparam logic [M-1:0] L_NOT_B  = 7;
  localparam logic [M-1:0] L_SHR1_A = 8;
  localparam logic [M-1:0] L_SHL1_A = 9;
  localparam logic [M-1:0] L_SHR1_B = 10;
  localparam logic [M-1:0] L_SHL1_B = 11;
  localparam logic [M-1:0] L_ROL    = 12;
  localparam logic [M-1:0] L_ROR    = 13;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_EXEC, S_EXEC2, S_DONE} state_t;

  // Operands an opcode depends on: bit0 = A, bit1 = B.
  function automatic logic [1:0] needs(input logic m, input logic [M-1:0] c);
    logic [1:0] n;
    n = 2'b11;
    if (m) begin
      if (c == A_INC_A || c == A_DEC_A)      n = 2'b01;
      else if (c == A_INC_B || c == A_DEC_B) n = 2'b10;
    end else begin
      if (c == L_NOT_A || c == L_SHR1_A || c == L_SHL1_A)      n = 2'b01;
      else if (c == L_NOT_B || c == L_SHR1_B || c == L_SHL1_B) n = 2'b10;
    end
    return n;
  endfunction

  function automatic logic op_ok(input logic m, input logic [M-1:0] c);
    return m ? (c <= A_MUL_SHL) : (c <= L_ROR);
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      have_q, have_d;
  logic            start, timeout, bad_op;
  logic [1:0]      need_in, need_q;

  logic            mode_q, cin_q;
  logic [M-1:0]    cmd_q;
  logic [N-1:0]    a_q, b_q;
  logic [N:0]      fa_q, fb_q;

  logic [2*N-1:0]  r_res;
  logic            r_cout, r_oflow, r_e, r_g, r_l, r_err;

  logic            is_mul_q;
  logic [N:0]      a_x, b_x, add_ab, add_abc, sub_ab, sub_abc, bc_x;
  logic [N:0]      inc_a, dec_a, inc_b, dec_b;
  logic [SW-1:0]   sh;
  logic [N-1:0]    rol, ror;
  logic            rot_err;

  logic [2*N-1:0]  c_res;
  logic [N:0]      ar;
  logic [N-1:0]    lg;
  logic            use_lg;
  logic            c_cout, c_oflow, c_e, c_g, c_l, c_err;

  assign is_mul_q = mode_q && (cmd_q == A_MUL_INC || cmd_q == A_MUL_SHL);
  assign bus.busy = (state_q != S_IDLE);

  assign a_x     = {1'b0, a_q};
  assign b_x     = {1'b0, b_q};
  assign add_ab  = a_x + b_x;
  assign add_abc = a_x + b_x + {{N{1'b0}}, cin_q};
  assign sub_ab  = a_x - b_x;
  assign sub_abc = a_x - b_x - {{N{1'b0}}, cin_q};
  assign bc_x    = b_x + {{N{1'b0}}, cin_q};
  assign inc_a   = a_x + ONE;
  assign dec_a   = a_x - ONE;
  assign inc_b   = b_x + ONE;
  assign dec_b   = b_x - ONE;
  assign sh      = b_q[SW-1:0];
  assign rol     = (a_q << sh) | (a_q >> (NW - {1'b0, sh}));
  assign ror     = (a_q >> sh) | (a_q << (NW - {1'b0, sh}));
  assign rot_err = |(b_q >> SW);

  // Next-state logic: operand collection, bounded wait and execute sequencing.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    have_d  = have_q;
    start   = 1'b0;
    timeout = 1'b0;
    bad_op  = 1'b0;
    need_in = needs(bus.mode, bus.cmd);
    need_q  = needs(mode_q, cmd_q);
    case (state_q)
      S_IDLE: begin
        if (bus.inp_valid != 2'b00) begin
          start  = 1'b1;
          have_d = bus.inp_valid;
          if (!op_ok(bus.mode, bus.cmd)) begin
            bad_op  = 1'b1;
            state_d = S_DONE;
          end else if ((need_in & ~bus.inp_valid) == 2'b00) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      S_WAIT: begin
        have_d = have_q | bus.inp_valid;
        if ((need_q & ~have_d) == 2'b00) begin
          state_d = S_EXEC;
        end else if (cnt_q == CW'(WAIT_CYCLES)) begin
          timeout = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXEC:  state_d = is_mul_q ? S_EXEC2 : S_DONE;
      S_EXEC2: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter and operand-present bookkeeping; frozen while ce is low.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      have_q  <= '0;
    end else if (bus.ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      have_q  <= have_d;
    end
  end

  // Command and operand capture: command on start, operands in IDLE or WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= 1'b0;
      cmd_q  <= '0;
      cin_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (bus.ce) begin
      if (start) begin
        mode_q <= bus.mode;
        cmd_q  <= bus.cmd;
        cin_q  <= bus.cin;
      end
      if ((start || state_q == S_WAIT) && bus.inp_valid[0]) a_q <= bus.opa;
      if ((start || state_q == S_WAIT) && bus.inp_valid[1]) b_q <= bus.opb;
    end
  end

  // Single-cycle ALU function of the latched command and operands.
  always_comb begin
    ar      = '0;
    lg      = '0;
    use_lg  = 1'b0;
    c_cout  = 1'b0;
    c_oflow = 1'b0;
    c_e     = 1'b0;
    c_g     = 1'b0;
    c_l     = 1'b0;
    c_err   = 1'b0;
    if (mode_q) begin
      case (cmd_q)
        A_ADD:     begin ar = add_ab;  c_cout  = add_ab[N];  end
        A_SUB:     begin ar = sub_ab;  c_oflow = (a_x < b_x); end
        A_ADD_CIN: begin ar = add_abc; c_cout  = add_abc[N]; end
        A_SUB_CIN: begin ar = sub_abc; c_oflow = (a_x < bc_x); end
        A_INC_A:   begin ar = inc_a;   c_cout  = inc_a[N];   end
        A_DEC_A:   begin ar = dec_a;   c_oflow = (a_q == '0); end
        A_INC_B:   begin ar = inc_b;   c_cout  = inc_b[N];   end
        A_DEC_B:   begin ar = dec_b;   c_oflow = (b_q == '0); end
        A_CMP: begin
          c_e = (a_q == b_q);
          c_g = (a_q > b_q);
          c_l = (a_q < b_q);
        end
        A_MUL_INC, A_MUL_SHL: ar = '0;  // product is formed in EXEC2
        default: c_err = 1'b1;
      endcase
    end else begin
      use_lg = 1'b1;
      case (cmd_q)
        L_AND:    lg = a_q & b_q;
        L_NAND:   lg = ~(a_q & b_q);
        L_OR:     lg = a_q | b_q;
        L_NOR:    lg = ~(a_q | b_q);
        L_XOR:    lg = a_q ^ b_q;
        L_XNOR:   lg = ~(a_q ^ b_q);
        L_NOT_A:  lg = ~a_q;
        L_NOT_B:  lg = ~b_q;
        L_SHR1_A: lg = a_q >> 1;
        L_SHL1_A: lg = a_q << 1;
        L_SHR1_B: lg = b_q >> 1;
        L_SHL1_B: lg = b_q << 1;
        L_ROL:    begin lg = rol; c_err = rot_err; end
        L_ROR:    begin lg = ror; c_err = rot_err; end
        default:  c_err = 1'b1;
      endcase
    end
    c_res = use_lg ? {{N{1'b0}}, lg} : {{(N-1){1'b0}}, ar};
  end

  // Result pipeline: EXEC/EXEC2 fill the staging registers, DONE publishes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fa_q          <= '0;
      fb_q          <= '0;
      r_res         <= '0;
      r_cout        <= 1'b0;
      r_oflow       <= 1'b0;
      r_e           <= 1'b0;
      r_g           <= 1'b0;
      r_l           <= 1'b0;
      r_err         <= 1'b0;
      bus.res       <= '0;
      bus.res_valid <= 1'b0;
      bus.cout      <= 1'b0;
      bus.oflow     <= 1'b0;
      bus.e         <= 1'b0;
      bus.g         <= 1'b0;
      bus.l         <= 1'b0;
      bus.err       <= 1'b0;
    end else if (bus.ce) begin
      bus.res_valid <= 1'b0;
      case (state_q)
        S_IDLE, S_WAIT: begin
          if (bad_op || timeout) begin
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_oflow <= 1'b0;
            r_e     <= 1'b0;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        S_EXEC: begin
          r_res   <= c_res;
          r_cout  <= c_cout;
          r_oflow <= c_oflow;
          r_e     <= c_e;
          r_g     <= c_g;
          r_l     <= c_l;
          r_err   <= c_err;
          if (cmd_q == A_MUL_INC) begin
            fa_q <= a_x + ONE;
            fb_q <= b_x + ONE;
          end else begin
            fa_q <= {a_q, 1'b0};
            fb_q <= b_x;
          end
        end
        S_EXEC2: r_res <= {{(N-1){1'b0}}, fa_q} * {{(N-1){1'b0}}, fb_q};
        S_DONE: begin
          bus.res       <= r_res;
          bus.cout      <= r_cout;
          bus.oflow     <= r_oflow;
          bus.e         <= r_e;
          bus.g         <= r_g;
          bus.l         <= r_l;
          bus.err       <= r_err;
          bus.res_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pipe_core.sv
// Bench for alu_pipe_core: directed scenarios followed by random operations,
// each compared with an arithmetic reference model of the opcode table.
module tb_alu_pipe_core;
  localparam int N           = 8;
  localparam int M           = 4;
  localparam int WAIT_CYCLES = 16;
  localparam int NMASK       = (1 << N) - 1;
  localparam int N1MASK      = (1 << (N + 1)) - 1;
  localparam int RMASK       = (1 << (2 * N)) - 1;

  typedef struct {
    logic [2*N-1:0] res;
    logic [5:0]     flags;  // {cout, oflow, e, g, l, err}
    int             lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  alu_pipe_core_if #(.N(N), .M(M)) bus ();

  alu_pipe_core #(.N(N), .M(M), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic mode, input int cmd, input int a,
                                 input int b, input int cin);
    exp_t x;
    int   r;
    int   s;
    logic cout, oflow, e, g, l, err;
    r = 0; cout = 0; oflow = 0; e = 0; g = 0; l = 0; err = 0;
    x.lat = 2;
    s = b % N;
    if (mode) begin
      case (cmd)
        0:  begin r = a + b;               cout  = (r > NMASK); end
        1:  begin r = (a - b) & N1MASK;     oflow = (a < b); end
        2:  begin r = a + b + cin;         cout  = (r > NMASK); end
        3:  begin r = (a - b - cin) & N1MASK; oflow = (a < b + cin); end
        4:  begin r = a + 1;               cout  = (r > NMASK); end
        5:  begin r = (a - 1) & N1MASK;     oflow = (a == 0); end
        6:  begin r = b + 1;               cout  = (r > NMASK); end
        7:  begin r = (b - 1) & N1MASK;     oflow = (b == 0); end
        8:  begin e = (a == b); g = (a > b); l = (a < b); end
        9:  begin r = ((a + 1) * (b + 1)) & RMASK; x.lat = 3; end
        10: begin r = (2 * a * b) & RMASK;        x.lat = 3; end
        default: begin err = 1; x.lat = 1; end
      endcase
    end else begin
      case (cmd)
        0:  r = a & b;
        1:  r = ~(a & b) & NMASK;
        2:  r = a | b;
        3:  r = ~(a | b) & NMASK;
        4:  r = a ^ b;
        5:  r = ~(a ^ b) & NMASK;
        6:  r = ~a & NMASK;
        7:  r = ~b & NMASK;
        8:  r = a / 2;
        9:  r = (a * 2) & NMASK;
        10: r = b / 2;
        11: r = (b * 2) & NMASK;
        12: begin r = ((a << s) | (a >> (N - s))) & NMASK; err = (b >= N); end
        13: begin r = ((a >> s) | (a << (N - s))) & NMASK; err = (b >= N); end
        default: begin err = 1; x.lat = 1; end
      endcase
    end
    x.res   = (2*N)'(r);
    x.flags = {cout, oflow, e, g, l, err};
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mode, input int cmd, input int a, input int b,
                       input int cin, input logic [1:0] valid);
    bus.mode      = mode;
    bus.cmd       = M'(cmd);
    bus.opa       = N'(a);
    bus.opb       = N'(b);
    bus.cin       = cin[0];
    bus.inp_valid = valid;
  endtask

  // Waits for res_valid (bounded), then checks latency, result, flags and strobe width.
  task automatic collect(input string tag, input exp_t x, input int edges_so_far);
    int lat;
    logic [2*N-1:0] held;
    lat = -1;
    for (int k = edges_so_far + 1; k <= edges_so_far + 40; k++) begin
      tick();
      if (bus.res_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, ".lat"}, lat, x.lat);
    if (lat >= 0) begin
      check({tag, ".res"}, bus.res, x.res);
      check({tag, ".flags"}, {bus.cout, bus.oflow, bus.e, bus.g, bus.l, bus.err}, x.flags);
      check({tag, ".busy"}, bus.busy, 1'b0);
      held = bus.res;
      tick();
      check({tag, ".strobe"}, bus.res_valid, 1'b0);
      check({tag, ".hold"}, bus.res, held);
    end
  endtask

  task automatic run_op(input string tag, input logic mode, input int cmd,
                        input int a, input int b, input int cin);
    drive(mode, cmd, a, b, cin, 2'b11);
    tick();
    bus.inp_valid = 2'b00;
    bus.opa       = N'($urandom);
    bus.opb       = N'($urandom);
    bus.cmd       = M'($urandom);
    check({tag, ".busy_run"}, bus.busy, 1'b1);
    collect(tag, model(mode, cmd, a, b, cin), 0);
  endtask

  initial begin
    exp_t x;
    logic seen;
    int   md, cm, a, b, c;

    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 2'b00);
    bus.ce = 1'b1;
    #2;
    check("reset.res", bus.res, 0);
    check("reset.flags", {bus.cout, bus.oflow, bus.e, bus.g, bus.l, bus.err}, 0);
    check("reset.valid", bus.res_valid, 1'b0);
    check("reset.busy", bus.busy, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    run_op("add_200_100", 1'b1, 0, 200, 100, 0);
    run_op("mul_inc_15", 1'b1, 9, 15, 15, 0);

    // Split operands: OPA now, OPB six cycles later, junk command in between.
    drive(1'b1, 0, 5, 0, 0, 2'b01);
    tick();
    bus.inp_valid = 2'b00;
    bus.cmd       = 4'd4;
    bus.mode      = 1'b0;
    check("split.busy", bus.busy, 1'b1);
    repeat (5) tick();
    bus.opa       = 8'd99;
    bus.opb       = 8'd7;
    bus.inp_valid = 2'b10;
    tick();
    bus.inp_valid = 2'b00;
    collect("split_add", model(1'b1, 0, 5, 7, 0), 0);

    // Missing operand never arrives: error after the full wait budget.
    drive(1'b1, 0, 9, 0, 0, 2'b01);
    tick();
    bus.inp_valid = 2'b00;
    x.res   = '0;
    x.flags = 6'b000001;
    x.lat   = WAIT_CYCLES + 1;
    collect("timeout", x, 0);
    run_op("after_timeout", 1'b1, 0, 17, 25, 0);

    run_op("rol_81_11", 1'b0, 12, 8'h81, 8'h11, 0);
    run_op("logic_cmd15", 1'b0, 15, 3, 4, 0);
    run_op("arith_cmd11", 1'b1, 11, 3, 4, 0);
    run_op("sub_borrow", 1'b1, 1, 5, 7, 0);
    run_op("dec_a_zero", 1'b1, 5, 0, 0, 0);

    // ce low while res_valid is up: strobe and result stay frozen.
    drive(1'b1, 0, 1, 2, 0, 2'b11);
    tick();
    bus.inp_valid = 2'b00;
    tick();
    check("ce_hold.early", bus.res_valid, 1'b0);
    tick();
    check("ce_hold.valid", bus.res_valid, 1'b1);
    bus.ce = 1'b0;
    repeat (3) tick();
    check("ce_hold.still_valid", bus.res_valid, 1'b1);
    check("ce_hold.res", bus.res, 16'd3);
    bus.ce = 1'b1;
    tick();
    check("ce_hold.released", bus.res_valid, 1'b0);

    // ce low for 5 cycles during WAIT stretches the timeout by 5 cycles.
    drive(1'b1, 0, 9, 0, 0, 2'b01);
    tick();
    bus.inp_valid = 2'b00;
    repeat (3) tick();
    bus.ce = 1'b0;
    repeat (5) tick();
    check("ce_wait.busy", bus.busy, 1'b1);
    bus.ce = 1'b1;
    x.res   = '0;
    x.flags = 6'b000001;
    x.lat   = WAIT_CYCLES + 1 + 5;
    collect("ce_wait_timeout", x, 8);

    // Reset while a multiply sits in EXEC2.
    run_op("pre_reset_add", 1'b1, 0, 200, 100, 0);
    drive(1'b1, 9, 20, 30, 0, 2'b11);
    tick();
    bus.inp_valid = 2'b00;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid.res", bus.res, 0);
    check("rst_mid.flags", {bus.cout, bus.oflow, bus.e, bus.g, bus.l, bus.err}, 0);
    check("rst_mid.valid", bus.res_valid, 1'b0);
    check("rst_mid.busy", bus.busy, 1'b0);
    #1;
    rst  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | bus.res_valid;
    end
    check("rst_mid.no_valid", seen, 1'b0);
    run_op("post_reset_mul", 1'b1, 10, 200, 150, 0);

    for (int i = 0; i < 60; i++) begin
      md = $urandom_range(0, 1);
      cm = $urandom_range(0, 15);
      a  = $urandom_range(0, NMASK);
      b  = (i % 4 == 0) ? $urandom_range(0, 7) : $urandom_range(0, NMASK);
      c  = $urandom_range(0, 1);
      run_op($sformatf("rnd%0d_m%0d_c%0d", i, md, cm), md[0], cm, a, b, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_pipe_core.md
Name: alu_pipe_core

Overview:
- Parametrised, handshaked ALU core; the next generation of the block driven by the team's ALU interface.
- Generalises the operand width to N and the command width to M.
- Adds three features:
  - split-operand collection: OPA and OPB may arrive in different cycles, with a bounded wait;
  - a 2-cycle multiply path;
  - a RES_VALID strobe and a BUSY output.
- Sits between the stimulus driver and the result monitor.

Parameters:
- N, 8, operand width in bits (≥4, power of 2).
- M, 4, CMD width in bits.
- WAIT_CYCLES, 16, number of cycles allowed for the missing operand to arrive before ERR.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  reset; asynchronous, active-low
- CE  input  1  clock enable; 0 freezes all state, counters and outputs
- MODE  input  1  1 = arithmetic, 0 = logical
- CMD  input  M  opcode
- INP_VALID  input  2  operand valid; bit0 = OPA, bit1 = OPB
- OPA  input  N  operand A
- OPB  input  N  operand B
- CIN  input  1  carry in
- RES  output  2N  result, zero-extended
- RES_VALID  output  1  one-cycle strobe; RES and all flags are valid
- BUSY  output  1  high while not in IDLE
- COUT  output  1  carry/borrow
- OFLOW  output  1  overflow
- E, G, L  output  1 each  compare flags
- ERR  output  1  error

Behaviour:
- Reset (RST=0, asynchronous): state = IDLE; wait counter = 0; operand registers = 0; all outputs = 0.
- All transitions and loads happen only on a CLK edge with CE=1.
- Opcodes, MODE=1:
  - 0 ADD; 1 SUB; 2 ADD_CIN; 3 SUB_CIN
  - 4 INC_A; 5 DEC_A; 6 INC_B; 7 DEC_B
  - 8 CMP
  - 9 MUL_INC = (A+1)*(B+1); 10 MUL_SHL = (A<<1)*B
- Opcodes, MODE=0:
  - 0 AND; 1 NAND; 2 OR; 3 NOR; 4 XOR; 5 XNOR
  - 6 NOT_A; 7 NOT_B
  - 8 SHR1_A; 9 SHL1_A; 10 SHR1_B; 11 SHL1_B
  - 12 ROL_A_B (rotate A left by B); 13 ROR_A_B (rotate A right by B)
- Operand needs:
  - A only: INC_A, DEC_A, NOT_A, SHR1_A, SHL1_A.
  - B only: INC_B, DEC_B, NOT_B, SHR1_B, SHL1_B.
  - All other opcodes need both.
- Invalid opcode (arithmetic >10, logical >13): ERR=1, RES=0, RES_VALID strobe on the next cycle.
- State machine:
  - IDLE: when INP_VALID≠00, latch CMD, MODE, CIN and whichever operands are valid.
    - If all needed operands are present, go to EXEC.
    - Otherwise go to WAIT with counter = 1.
    - INP_VALID=00 keeps IDLE.
  - WAIT: each cycle, latch any newly valid operand; CMD/MODE are ignored.
    - All needed operands present: go to EXEC.
    - Counter reaches WAIT_CYCLES with an operand still missing: go to DONE with ERR=1, RES=0.
  - EXEC: compute. Non-multiply goes to DONE; multiply stays one extra cycle (EXEC2), then goes to DONE.
  - DONE: register RES/flags and pulse RES_VALID=1 for one cycle, then go to IDLE.
    - BUSY is high in WAIT, EXEC, EXEC2 and DONE; it deasserts in the cycle RES_VALID is high.
- Latency, measured from the edge that captures the last needed operand to RES_VALID: 2 cycles for non-multiply, 3 cycles for multiply.
- Inputs are ignored while BUSY, except operand capture in WAIT. No queuing.
- Arithmetic and width rules:
  - ADD/ADD_CIN: RES = A+B(+CIN), N+1 bits; COUT = bit N.
  - SUB/SUB_CIN: RES = (A−B(−CIN)) mod 2^(N+1); OFLOW = 1 when A < B(+CIN).
  - INC/DEC: N+1-bit result; COUT on INC overflow; OFLOW on DEC of 0.
  - CMP: exactly one of E/G/L = 1; RES = 0.
  - MUL: full 2N-bit product; A+1 and A<<1 are computed in N+1 bits.
  - Logical results: N bits.
  - ROL/ROR: rotate amount = OPB[log2N−1:0]; ERR = 1 if any higher bit of OPB is set, but the rotation is still performed.
- Flags not defined for an opcode are 0. Flags and RES hold their value until the next RES_VALID.
- CE=0 in any state: freeze everything, including the wait counter. RES_VALID stays asserted for as long as CE is held low in the DONE cycle.
- Reset mid-operation: abort immediately, go to IDLE, no RES_VALID.

Test Plan:
- N=8, MODE=1, CMD=0, OPA=200, OPB=100, INP_VALID=11 -> 2 cycles later RES_VALID=1, RES=300 (0x12C), COUT=1, BUSY low afterwards.
- MODE=1, CMD=9, OPA=15, OPB=15 -> RES_VALID 3 cycles after capture, RES=256, ERR=0.
- CMD=0 (ADD): INP_VALID=01 with OPA=5, then 10 with OPB=7 six cycles later -> RES=12; RES_VALID 2 cycles after the OPB cycle.
- INP_VALID=01 only for an ADD, never followed by OPB -> ERR=1, RES=0, RES_VALID asserted once WAIT_CYCLES=16 has expired; the next op proceeds normally.
- MODE=0, CMD=12, OPA=0x81, OPB=0x11 -> RES=0x03, ERR=1; CMD=15 (logical) -> ERR=1.
- RST low during EXEC2 of a multiply -> all outputs 0 immediately, no RES_VALID; CE=0 held 5 cycles in WAIT -> timeout is extended by 5 cycles.
